game_clock_ctrl: RTL and testbench
==================================

Name: game_clock_ctrl

Overview:
Sequences the basketball game clock for the scoreboard. Consumes the divided slow clock, turns each rising edge into a one-cycle tick, and runs a start/pause/expire/period state machine. Counts down minutes:seconds per period and drives the end-of-period buzzer. Sits between the clock divider and the seven-segment display/score logic; all logic runs on the board clock.

Parameters:
PERIOD_MIN, 12, minutes loaded at the start of each period; legal range 1..99.
NUM_PERIODS, 4, number of periods per game; legal range 1..7.
BUZZ_TICKS, 3, ticks the buzzer stays on at period end; legal range 1..15.

Ports:
clk  input  1  board clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
sclk  input  1  divided slow clock from the clock divider; same clk domain, no synchroniser.
start  input  1  single-cycle pulse (debounced); start or resume the clock.
stop  input  1  single-cycle pulse (debounced); pause the clock.
new_game  input  1  single-cycle pulse; synchronous return to reset state.
minutes  output  7  remaining minutes, binary 0..99.
seconds  output  6  remaining seconds, binary 0..59.
period  output  3  current period, 1..NUM_PERIODS.
running  output  1  1 only in RUN.
buzzer  output  1  1 only in BUZZ.
game_over  output  1  1 only in DONE.

Behaviour:
- Reset (reset=0 or new_game=1): state=IDLE, minutes=PERIOD_MIN, seconds=0, period=1, running=0, buzzer=0, game_over=0, sclk_q=0, buzz_cnt=0. new_game overrides all other inputs in the same cycle.
- Tick: sclk_q registers sclk each cycle. tick=sclk & ~sclk_q is combinational. A tick is one clk cycle wide; the first tick after reset needs a 0->1 edge of sclk.
- States: IDLE, RUN, PAUSE, BUZZ, DONE. Outputs are registered and follow the state with no extra latency.
- IDLE: start -> RUN on the next edge. Ticks are ignored.
- RUN: stop -> PAUSE. If stop and tick occur in the same cycle, stop wins and the time is not decremented. start in RUN is ignored.
- RUN, tick with no stop: if seconds>0, seconds-1. If seconds=0 and minutes>0, seconds=59 and minutes-1.
- Expiry: a tick that lands on 0:00 (from 0:01) enters BUZZ in the same edge, with buzz_cnt=0.
- PAUSE: start -> RUN. stop is ignored. Ticks are ignored and the time holds.
- If start and stop arrive together in IDLE or PAUSE, stop wins and the state is unchanged.
- BUZZ: start and stop are ignored. Each tick increments buzz_cnt.
- BUZZ exit: on the tick where buzz_cnt reaches BUZZ_TICKS-1:
  - if period<NUM_PERIODS: period+1, minutes=PERIOD_MIN, seconds=0, go to IDLE.
  - else go to DONE with the time held at 0:00.
- DONE: holds until reset or new_game. start and stop are ignored.
- Widths: the decrement never underflows because RUN leaves at 0:00. The period counter never exceeds NUM_PERIODS.

Test Plan:
- Reset values: PERIOD_MIN=12, reset low mid-count, then release -> 12:00, period=1, IDLE, all flags 0; the asynchronous clear is seen before the next clk edge.
- Countdown and wrap: start, then 1 tick -> 11:59, running=1; 59 more ticks -> 11:00; the tick count matches the number of sclk rising edges, with no double count on the falling edge.
- Pause/resume: in RUN at 11:30, stop then 5 ticks -> 11:30 held, running=0; start then 1 tick -> 11:29. stop with a tick in the same cycle -> no decrement.
- Expiry and buzzer: PERIOD_MIN=1, BUZZ_TICKS=3, run 60 ticks -> 0:00, buzzer=1 for exactly 3 ticks. Then IDLE, period=2, 1:00, buzzer=0; start ignored during BUZZ.
- Game over: NUM_PERIODS=2, PERIOD_MIN=1, play both periods -> DONE, game_over=1, 0:00, period=2; start ignored; new_game -> 1:00, period=1, IDLE.
- Priority: in PAUSE, start and stop together -> stays PAUSE; in RUN, new_game with a tick -> IDLE, PERIOD_MIN:00.

Source files
------------

// File: rtl/game_clock_ctrl.sv
// Basketball game clock sequencer: turns sclk rising edges into ticks and runs the period countdown and buzzer.
// Outputs are registered and update on the clk edge after an input or tick; there is no backpressure, so start/stop pulses act in the cycle they arrive.
module game_clock_ctrl #(
  parameter int unsigned PERIOD_MIN  = 12,
  parameter int unsigned NUM_PERIODS = 4,
  parameter int unsigned BUZZ_TICKS  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       start,
  input  logic       stop,
  input  logic       new_game,
  output logic [6:0] minutes,
  output logic [5:0] seconds,
  output logic [2:0] period,
  output logic       running,
  output logic       buzzer,
  output logic       game_over
);

  typedef enum logic [2:0] {IDLE, RUN, PAUSE, BUZZ, DONE} state_t;

  state_t     state;
  logic       sclk_q;
  logic [3:0] buzz_cnt;
  logic       tick;
  logic       go;

  assign tick = sclk & ~sclk_q;
  // stop dominates start whenever both arrive together
  assign go   = start & ~stop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      minutes   <= 7'(PERIOD_MIN);
      seconds   <= 6'd0;
      period    <= 3'd1;
      running   <= 1'b0;
      buzzer    <= 1'b0;
      game_over <= 1'b0;
      sclk_q    <= 1'b0;
      buzz_cnt  <= 4'd0;
    end else begin
      sclk_q <= sclk;
      if (new_game) begin
        state     <= IDLE;
        minutes   <= 7'(PERIOD_MIN);
        seconds   <= 6'd0;
        period    <= 3'd1;
        running   <= 1'b0;
        buzzer    <= 1'b0;
        game_over <= 1'b0;
        sclk_q    <= 1'b0;
        buzz_cnt  <= 4'd0;
      end else begin
        case (state)
          IDLE, PAUSE: begin
            if (go) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (tick) begin
              if (seconds != 6'd0) begin
                seconds <= seconds - 6'd1;
                // landing on 0:00 starts the buzzer in the same edge
                if (seconds == 6'd1 && minutes == 7'd0) begin
                  state    <= BUZZ;
                  running  <= 1'b0;
                  buzzer   <= 1'b1;
                  buzz_cnt <= 4'd0;
                end
              end else if (minutes != 7'd0) begin
                seconds <= 6'd59;
                minutes <= minutes - 7'd1;
              end
            end
          end
          BUZZ: begin
            if (tick) begin
              if (buzz_cnt == 4'(BUZZ_TICKS - 1)) begin
                buzzer   <= 1'b0;
                buzz_cnt <= 4'd0;
                if (period < 3'(NUM_PERIODS)) begin
                  state   <= IDLE;
                  period  <= period + 3'd1;
                  minutes <= 7'(PERIOD_MIN);
                  seconds <= 6'd0;
                end else begin
                  state     <= DONE;
                  game_over <= 1'b1;
                end
              end else begin
                buzz_cnt <= buzz_cnt + 4'd1;
              end
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
            buzzer  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_clock_ctrl.sv
// Bench for game_clock_ctrl: a 12-minute/4-period instance and a 1-minute/2-period instance,
// stimulus selected by sel, expected states queued per operation and compared after it.
module tb_game_clock_ctrl;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic sclk     = 1'b0;
  logic start    = 1'b0;
  logic stop     = 1'b0;
  logic new_game = 1'b0;
  logic sel      = 1'b0;

  logic [6:0] min_a, min_b;
  logic [5:0] sec_a, sec_b;
  logic [2:0] per_a, per_b;
  logic       run_a, run_b, buzz_a, buzz_b, over_a, over_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    int    mn;
    int    sc;
    int    pr;
    int    rn;
    int    bz;
    int    ov;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  game_clock_ctrl #(.PERIOD_MIN(12), .NUM_PERIODS(4), .BUZZ_TICKS(3)) u_a (
    .clk(clk), .reset(reset), .sclk(sclk & ~sel), .start(start & ~sel),
    .stop(stop & ~sel), .new_game(new_game & ~sel),
    .minutes(min_a), .seconds(sec_a), .period(per_a),
    .running(run_a), .buzzer(buzz_a), .game_over(over_a)
  );

  game_clock_ctrl #(.PERIOD_MIN(1), .NUM_PERIODS(2), .BUZZ_TICKS(3)) u_b (
    .clk(clk), .reset(reset), .sclk(sclk & sel), .start(start & sel),
    .stop(stop & sel), .new_game(new_game & sel),
    .minutes(min_b), .seconds(sec_b), .period(per_b),
    .running(run_b), .buzzer(buzz_b), .game_over(over_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int mn, input int sc, input int pr,
                          input int rn, input int bz, input int ov);
    exp_t e;
    e.tag = tag; e.mn = mn; e.sc = sc; e.pr = pr; e.rn = rn; e.bz = bz; e.ov = ov;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      chk({e.tag, ".min"},  sel ? int'(min_b)  : int'(min_a),  e.mn);
      chk({e.tag, ".sec"},  sel ? int'(sec_b)  : int'(sec_a),  e.sc);
      chk({e.tag, ".per"},  sel ? int'(per_b)  : int'(per_a),  e.pr);
      chk({e.tag, ".run"},  sel ? int'(run_b)  : int'(run_a),  e.rn);
      chk({e.tag, ".buzz"}, sel ? int'(buzz_b) : int'(buzz_a), e.bz);
      chk({e.tag, ".over"}, sel ? int'(over_b) : int'(over_a), e.ov);
    end
  endtask

  task automatic step(input logic st, input logic sp, input logic ng, input logic sc);
    @(negedge clk);
    start = st; stop = sp; new_game = ng; sclk = sc;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; new_game = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // asynchronous clear must show before any clock edge
    #1 reset = 1'b0;
    #1;
    push_exp("rst_async", 12, 0, 1, 0, 0, 0); pop_cmp();
    @(negedge clk); reset = 1'b1;

    push_exp("start", 12, 0, 1, 1, 0, 0);        step(1, 0, 0, 0); pop_cmp();
    push_exp("tick1", 11, 59, 1, 1, 0, 0);       ticks(1);         pop_cmp();
    push_exp("to_1130", 11, 30, 1, 1, 0, 0);     ticks(29);        pop_cmp();
    push_exp("stop", 11, 30, 1, 0, 0, 0);        step(0, 1, 0, 0); pop_cmp();
    push_exp("pause_hold", 11, 30, 1, 0, 0, 0);  ticks(5);         pop_cmp();
    push_exp("resume", 11, 30, 1, 1, 0, 0);      step(1, 0, 0, 0); pop_cmp();
    push_exp("resume_tick", 11, 29, 1, 1, 0, 0); ticks(1);         pop_cmp();
    push_exp("to_1100", 11, 0, 1, 1, 0, 0);      ticks(29);        pop_cmp();
    push_exp("wrap", 10, 59, 1, 1, 0, 0);        ticks(1);         pop_cmp();

    // sclk held high for several clocks is still one tick
    push_exp("long_high", 10, 58, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    pop_cmp();

    push_exp("stop_tick", 10, 58, 1, 0, 0, 0);
    step(0, 1, 0, 1); step(0, 0, 0, 0); pop_cmp();
    push_exp("pause_both", 10, 58, 1, 0, 0, 0);  step(1, 1, 0, 0); pop_cmp();
    push_exp("pause_tick", 10, 58, 1, 0, 0, 0);  ticks(2);         pop_cmp();
    push_exp("resume2", 10, 58, 1, 1, 0, 0);     step(1, 0, 0, 0); pop_cmp();
    push_exp("run_tick", 10, 57, 1, 1, 0, 0);    ticks(1);         pop_cmp();

    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    push_exp("rst_mid", 12, 0, 1, 0, 0, 0); pop_cmp();
    @(negedge clk); reset = 1'b1;

    push_exp("idle_both", 12, 0, 1, 0, 0, 0);    step(1, 1, 0, 0); pop_cmp();
    push_exp("idle_tick", 12, 0, 1, 0, 0, 0);    ticks(1);         pop_cmp();
    push_exp("start2", 12, 0, 1, 1, 0, 0);       step(1, 0, 0, 0); pop_cmp();
    push_exp("run_start", 11, 59, 1, 1, 0, 0);
    step(1, 0, 0, 1); step(0, 0, 0, 0); pop_cmp();
    push_exp("ng_tick", 12, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1); step(0, 0, 0, 0); pop_cmp();

    sel = 1'b1;
    push_exp("b_idle", 1, 0, 1, 0, 0, 0);        step(0, 0, 0, 0); pop_cmp();
    push_exp("b_start", 1, 0, 1, 1, 0, 0);       step(1, 0, 0, 0); pop_cmp();
    push_exp("b_0_01", 0, 1, 1, 1, 0, 0);        ticks(59);        pop_cmp();
    push_exp("b_expire", 0, 0, 1, 0, 1, 0);      ticks(1);         pop_cmp();
    push_exp("b_buzz_start", 0, 0, 1, 0, 1, 0);  step(1, 0, 0, 0); pop_cmp();
    push_exp("b_buzz1", 0, 0, 1, 0, 1, 0);       ticks(1);         pop_cmp();
    push_exp("b_buzz2", 0, 0, 1, 0, 1, 0);       ticks(1);         pop_cmp();
    push_exp("b_period2", 1, 0, 2, 0, 0, 0);     ticks(1);         pop_cmp();
    push_exp("b_p2_start", 1, 0, 2, 1, 0, 0);    step(1, 0, 0, 0); pop_cmp();
    push_exp("b_p2_zero", 0, 0, 2, 0, 1, 0);     ticks(60);        pop_cmp();
    push_exp("b_p2_buzz", 0, 0, 2, 0, 1, 0);     ticks(2);         pop_cmp();
    push_exp("b_done", 0, 0, 2, 0, 0, 1);        ticks(1);         pop_cmp();
    push_exp("b_done_start", 0, 0, 2, 0, 0, 1);  step(1, 0, 0, 0); pop_cmp();
    push_exp("b_done_stop", 0, 0, 2, 0, 0, 1);   step(0, 1, 0, 0); pop_cmp();
    push_exp("b_done_tick", 0, 0, 2, 0, 0, 1);   ticks(3);         pop_cmp();
    push_exp("b_ng_start", 1, 0, 1, 0, 0, 0);    step(1, 0, 1, 0); pop_cmp();

    chk("sb_drain", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
